// File: rtl/turn_controller_pkg.sv
// Shared types and encodings for the artillery-game turn sequencer.
package turn_controller_pkg;

  localparam int unsigned HP_W    = 10;
  localparam int unsigned TIMER_W = 5;
  localparam int unsigned WINS_W  = 4;

  typedef logic player_id_t;
  localparam player_id_t P1 = 1'b0;
  localparam player_id_t P2 = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REGEN     = 3'd1;
  localparam logic [2:0] ST_TURN      = 3'd2;
  localparam logic [2:0] ST_FLIGHT    = 3'd3;
  localparam logic [2:0] ST_SETTLE    = 3'd4;
  localparam logic [2:0] ST_ROUND_END = 3'd5;
  localparam logic [2:0] ST_MATCH_END = 3'd6;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // One-hot turn grant for a player
  function automatic logic [1:0] grant(input player_id_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Player-facing signal bundle of the turn sequencer.
interface turn_controller_if;
  import turn_controller_pkg::*;

  logic                 start;
  logic [1:0]           launch;
  logic [1:0]           boomed;
  logic [HP_W-1:0]      hp1;
  logic [HP_W-1:0]      hp2;
  logic [1:0]           turn_en;
  logic [TIMER_W-1:0]   turn_timer;
  logic [WINS_W-1:0]    wins1;
  logic [WINS_W-1:0]    wins2;
  logic                 terrain_regen;
  logic                 round_over;
  logic [1:0]           winner;

  modport master (
    output start, launch, boomed, hp1, hp2,
    input  turn_en, turn_timer, wins1, wins2, terrain_regen, round_over, winner
  );

  modport slave (
    input  start, launch, boomed, hp1, hp2,
    output turn_en, turn_timer, wins1, wins2, terrain_regen, round_over, winner
  );

endinterface

// File: rtl/turn_controller_frame_tick.sv
// Brings the asynchronous frame strobe into clk and emits one tick per rising edge.
module turn_controller_frame_tick (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic [2:0] sync;

  // Two synchroniser flops, one history flop, registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[1:0], frame_clk};
      tick <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Match/turn sequencer: grants turns, times them off frame ticks, scores rounds.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned TURN_SEC       = 20,
  parameter int unsigned FLIGHT_MAX     = 255,
  parameter int unsigned SETTLE_FRAMES  = 30,
  parameter int unsigned WINS_TO_MATCH  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_clk,
  turn_controller_if.slave   bus
);

  localparam int unsigned FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int unsigned LW = (FLIGHT_MAX > 1)     ? $clog2(FLIGHT_MAX)     : 1;
  localparam int unsigned SW = (SETTLE_FRAMES > 1)  ? $clog2(SETTLE_FRAMES)  : 1;
  localparam logic [FW-1:0] FPS_LAST = FW'((FRAMES_PER_SEC > 0) ? FRAMES_PER_SEC - 1 : 0);
  localparam logic [LW-1:0] FLT_LAST = LW'((FLIGHT_MAX > 0)     ? FLIGHT_MAX - 1     : 0);
  localparam logic [SW-1:0] SET_LAST = SW'((SETTLE_FRAMES > 0)  ? SETTLE_FRAMES - 1  : 0);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TURN_SEC);
  localparam logic [WINS_W-1:0]  WINS_GOAL  = WINS_W'(WINS_TO_MATCH);
  localparam logic [WINS_W-1:0]  WINS_SAT   = '1;

  logic                tick;
  logic [2:0]          state, state_n;
  player_id_t          cur, cur_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [FW-1:0]       fcnt, fcnt_n;
  logic [LW-1:0]       flt_cnt, flt_n;
  logic [SW-1:0]       set_cnt, set_n;
  logic [WINS_W-1:0]   wins1, wins1_n, wins2, wins2_n;
  logic [1:0]          winner, winner_n;
  logic                boom_q;

  turn_controller_frame_tick u_frame_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Next-state, counter and scoring decisions
  always_comb begin
    state_n  = state;
    cur_n    = cur;
    timer_n  = timer;
    fcnt_n   = fcnt;
    flt_n    = flt_cnt;
    set_n    = set_cnt;
    wins1_n  = wins1;
    wins2_n  = wins2;
    winner_n = winner;
    case (state)
      ST_IDLE, ST_MATCH_END: begin
        if (bus.start) begin
          state_n  = ST_REGEN;
          cur_n    = P1;
          wins1_n  = '0;
          wins2_n  = '0;
          winner_n = WIN_NONE;
        end
      end
      ST_REGEN: begin
        state_n = ST_TURN;
        timer_n = TIMER_LOAD;
        fcnt_n  = '0;
      end
      ST_TURN: begin
        if (bus.launch[cur]) begin
          state_n = ST_FLIGHT;
          flt_n   = '0;
        end else if (tick) begin
          if (fcnt == FPS_LAST) begin
            fcnt_n = '0;
            if (timer <= TIMER_W'(1)) begin
              timer_n = '0;
              state_n = ST_SETTLE;
              set_n   = '0;
            end else begin
              timer_n = timer - TIMER_W'(1);
            end
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end
      ST_FLIGHT: begin
        if (bus.boomed[cur] && !boom_q) begin
          state_n = ST_SETTLE;
          set_n   = '0;
        end else if (tick) begin
          if (flt_cnt == FLT_LAST) begin
            state_n = ST_SETTLE;
            set_n   = '0;
          end else begin
            flt_n = flt_cnt + LW'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (tick) begin
          if (set_cnt == SET_LAST) begin
            if (bus.hp1 == '0 || bus.hp2 == '0) begin
              state_n = ST_ROUND_END;
              if (bus.hp1 == '0 && bus.hp2 == '0) begin
                winner_n = WIN_DRAW;
              end else if (bus.hp2 == '0) begin
                winner_n = WIN_P1;
                if (wins1 != WINS_SAT) wins1_n = wins1 + WINS_W'(1);
              end else begin
                winner_n = WIN_P2;
                if (wins2 != WINS_SAT) wins2_n = wins2 + WINS_W'(1);
              end
            end else begin
              state_n = ST_TURN;
              cur_n   = ~cur;
              timer_n = TIMER_LOAD;
              fcnt_n  = '0;
            end
          end else begin
            set_n = set_cnt + SW'(1);
          end
        end
      end
      ST_ROUND_END: begin
        if ((winner == WIN_P1 && wins1 == WINS_GOAL) ||
            (winner == WIN_P2 && wins2 == WINS_GOAL)) begin
          state_n = ST_MATCH_END;
        end else begin
          state_n = ST_REGEN;
          cur_n   = (winner == WIN_P1) ? P2 : P1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      cur               <= P1;
      timer             <= '0;
      fcnt              <= '0;
      flt_cnt           <= '0;
      set_cnt           <= '0;
      wins1             <= '0;
      wins2             <= '0;
      winner            <= WIN_NONE;
      boom_q            <= 1'b0;
      bus.turn_en       <= 2'b00;
      bus.turn_timer    <= '0;
      bus.wins1         <= '0;
      bus.wins2         <= '0;
      bus.terrain_regen <= 1'b0;
      bus.round_over    <= 1'b0;
      bus.winner        <= WIN_NONE;
    end else begin
      state             <= state_n;
      cur               <= cur_n;
      timer             <= timer_n;
      fcnt              <= fcnt_n;
      flt_cnt           <= flt_n;
      set_cnt           <= set_n;
      wins1             <= wins1_n;
      wins2             <= wins2_n;
      winner            <= winner_n;
      boom_q            <= bus.boomed[cur];
      bus.turn_en       <= (state_n == ST_TURN) ? grant(cur_n) : 2'b00;
      bus.turn_timer    <= timer_n;
      bus.wins1         <= wins1_n;
      bus.wins2         <= wins2_n;
      bus.terrain_regen <= (state_n == ST_REGEN);
      bus.round_over    <= (state_n == ST_ROUND_END) || (state_n == ST_MATCH_END);
      bus.winner        <= winner_n;
    end
  end

endmodule
